// File: rtl/eth_tx_sched.sv
// Round-robin Ethernet transmit scheduler: grants one AXI-stream source for a whole
// frame, forwards it through a single output register, then enforces an inter-frame gap.
module eth_tx_sched #(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS-1:0]            s_axis_tuser,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tuser,
    input  logic                        m_axis_tready,
    output logic                        busy,
    output logic [$clog2(PORTS)-1:0]    active_port
);
    localparam int unsigned IDX_W = $clog2(PORTS);
    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_cnt_next;
    logic [PORTS-1:0]      mask_reg;
    logic [PORTS-1:0]      mask_next;
    logic [IDX_W-1:0]      active_next;
    logic [DATA_WIDTH-1:0] out_data_next;
    logic                  out_valid_next;
    logic                  out_last_next;
    logic                  out_user_next;
    logic                  busy_next;

    logic [PORTS-1:0]      req_masked;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  sel_user;
    logic                  out_space;
    logic                  src_accept;

    // Round-robin pick: lowest requester above the last grant, else lowest overall.
    always_comb begin
        req_masked = s_axis_tvalid & mask_reg;
        grant_any  = |s_axis_tvalid;
        grant_idx  = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if ((|req_masked) ? req_masked[i] : s_axis_tvalid[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Granted-source mux.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < PORTS; i++) begin
            if (active_port == IDX_W'(i)) begin
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    // Next-state, grant, output-register and gap-counter logic.
    always_comb begin
        state_next     = state;
        gap_cnt_next   = gap_cnt;
        mask_next      = mask_reg;
        active_next    = active_port;
        out_data_next  = m_axis_tdata;
        out_valid_next = m_axis_tvalid;
        out_last_next  = m_axis_tlast;
        out_user_next  = m_axis_tuser;
        s_axis_tready  = '0;
        out_space      = !m_axis_tvalid || m_axis_tready;
        src_accept     = 1'b0;

        // The output register drains in every state; a new load below overrides this.
        if (m_axis_tready) begin
            out_valid_next = 1'b0;
        end

        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next  = XFER;
                    active_next = grant_idx;
                    for (int i = 0; i < PORTS; i++) begin
                        mask_next[i] = (i > int'(grant_idx));
                    end
                end
            end
            XFER: begin
                for (int i = 0; i < PORTS; i++) begin
                    s_axis_tready[i] = (active_port == IDX_W'(i)) && out_space;
                end
                src_accept = sel_valid && out_space;
                if (src_accept) begin
                    out_data_next  = sel_data;
                    out_valid_next = 1'b1;
                    out_last_next  = sel_last;
                    out_user_next  = sel_user;
                    if (sel_last) begin
                        if (IFG_CYCLES > 0) begin
                            state_next   = GAP;
                            gap_cnt_next = GAP_W'(IFG_CYCLES);
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                gap_cnt_next = gap_cnt - GAP_W'(1);
                if (gap_cnt == GAP_W'(1)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            mask_reg      <= '0;
            active_port   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            gap_cnt       <= gap_cnt_next;
            mask_reg      <= mask_next;
            active_port   <= active_next;
            m_axis_tdata  <= out_data_next;
            m_axis_tvalid <= out_valid_next;
            m_axis_tlast  <= out_last_next;
            m_axis_tuser  <= out_user_next;
            busy          <= busy_next;
        end
    end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Bench for eth_tx_sched: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model (round-robin order, frame timing, one-entry output buffer).
module tb_eth_tx_sched;
    localparam int unsigned NP    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned IFG_A = 12;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP*DW-1:0] s_tdata;
    logic [NP-1:0] s_tvalid;
    logic [NP-1:0] s_tlast;
    logic [NP-1:0] s_tuser;
    logic          m_tready;

    logic [NP-1:0] tr_a, tr_b;
    logic [DW-1:0] md_a, md_b;
    logic          mv_a, mv_b, ml_a, ml_b, mu_a, mu_b, busy_a, busy_b;
    logic [1:0]    ap_a, ap_b;

    // sel = 0 checks the IFG=12 instance, sel = 1 the IFG=0 instance
    bit            sel;
    logic [NP-1:0] o_tr;
    logic [DW-1:0] o_md;
    logic          o_mv, o_ml, o_mu, o_busy;
    logic [1:0]    o_ap;

    assign o_tr   = sel ? tr_b   : tr_a;
    assign o_md   = sel ? md_b   : md_a;
    assign o_mv   = sel ? mv_b   : mv_a;
    assign o_ml   = sel ? ml_b   : ml_a;
    assign o_mu   = sel ? mu_b   : mu_a;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_ap   = sel ? ap_b   : ap_a;

    always #5 clk = ~clk;

    eth_tx_sched #(.PORTS(NP), .DATA_WIDTH(DW), .IFG_CYCLES(IFG_A)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(tr_a),
        .m_axis_tdata(md_a), .m_axis_tvalid(mv_a), .m_axis_tlast(ml_a),
        .m_axis_tuser(mu_a), .m_axis_tready(m_tready),
        .busy(busy_a), .active_port(ap_a)
    );

    eth_tx_sched #(.PORTS(NP), .DATA_WIDTH(DW), .IFG_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tuser(s_tuser), .s_axis_tready(tr_b),
        .m_axis_tdata(md_b), .m_axis_tvalid(mv_b), .m_axis_tlast(ml_b),
        .m_axis_tuser(mu_b), .m_axis_tready(m_tready),
        .busy(busy_b), .active_port(ap_b)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    beat_t src_q[NP][$];
    bit    mid[NP];
    bit    hold[NP];
    bit    gaps_en;
    bit    bp_en;
    logic  rdy_pat[$];

    int    cur, last_g, idle_at, ifg;
    bit    mfull;
    beat_t mbeat;

    int    acc_port[$];
    int    acc_cyc[$];
    int    last_cyc[$];
    int    out_cyc[$];
    beat_t out_log[$];

    int          exp_order[6] = '{0, 1, 3, 0, 1, 3};
    logic [7:0]  exp_a[3]     = '{8'hA1, 8'hA2, 8'hA3};
    logic [7:0]  exp_b[4]     = '{8'h31, 8'h32, 8'h33, 8'h34};
    int          nf, len, start;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(int p, logic [DW-1:0] d, logic l, logic u);
        beat_t b;
        b.data = d;
        b.last = l;
        b.user = u;
        src_q[p].push_back(b);
    endtask

    task automatic clear_logs();
        acc_port.delete();
        acc_cyc.delete();
        last_cyc.delete();
        out_cyc.delete();
        out_log.delete();
    endtask

    // Sources present their queue head; mid-frame bubbles only between accepted beats.
    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p]          = 1'b0;
            s_tlast[p]           = 1'b0;
            s_tuser[p]           = 1'b0;
            s_tdata[p*DW +: DW]  = '0;
            if (src_q[p].size() > 0 &&
                (hold[p] || !mid[p] || !gaps_en || $urandom_range(0, 1) == 0)) begin
                s_tvalid[p]         = 1'b1;
                s_tlast[p]          = src_q[p][0].last;
                s_tuser[p]          = src_q[p][0].user;
                s_tdata[p*DW +: DW] = src_q[p][0].data;
            end
        end
    endtask

    // One clock cycle: drive, check DUT against the model, advance the model.
    task automatic cycle();
        logic [NP-1:0] exp_tr;
        bit    space, idle_now, src_acc, out_acc;
        int    acc_p, pick;
        beat_t b;
        drive();
        if (rdy_pat.size() > 0) m_tready = rdy_pat.pop_front();
        else                    m_tready = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        space    = !mfull || m_tready;
        idle_now = (cur < 0) && (cyc >= idle_at);
        exp_tr   = '0;
        if (cur >= 0) exp_tr[cur] = space;
        chk("s_tready", 64'(o_tr), 64'(exp_tr));
        chk("busy", 64'(o_busy), 64'(!idle_now));
        chk("active_port", 64'(o_ap), 64'(cur >= 0 ? cur : (last_g < 0 ? 0 : last_g)));
        chk("m_tvalid", 64'(o_mv), 64'(mfull));
        if (mfull) begin
            chk("m_tdata", 64'(o_md), 64'(mbeat.data));
            chk("m_tlast", 64'(o_ml), 64'(mbeat.last));
            chk("m_tuser", 64'(o_mu), 64'(mbeat.user));
        end

        out_acc = mfull && m_tready;
        if (out_acc) begin
            out_log.push_back(mbeat);
            out_cyc.push_back(cyc);
        end
        acc_p   = cur;
        src_acc = (cur >= 0) && s_tvalid[cur] && space;
        if (src_acc) begin
            b = src_q[cur].pop_front();
            if (!mid[cur]) begin
                acc_port.push_back(cur);
                acc_cyc.push_back(cyc);
            end
            mid[cur] = !b.last;
            mfull    = 1'b1;
            mbeat    = b;
            if (b.last) begin
                last_cyc.push_back(cyc);
                idle_at = cyc + ifg + 1;
                cur     = -1;
            end
        end else if (out_acc) begin
            mfull = 1'b0;
        end
        for (int p = 0; p < NP; p++) begin
            hold[p] = s_tvalid[p] && !(src_acc && p == acc_p);
        end

        if (idle_now) begin
            pick = -1;
            for (int p = NP - 1; p >= 0; p--) if (s_tvalid[p] && p > last_g) pick = p;
            if (pick < 0) for (int p = NP - 1; p >= 0; p--) if (s_tvalid[p]) pick = p;
            if (pick >= 0) begin
                cur    = pick;
                last_g = pick;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive();
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        chk("rst_s_tready", 64'(o_tr), 64'(0));
        chk("rst_m_tvalid", 64'(o_mv), 64'(0));
        chk("rst_m_tdata", 64'(o_md), 64'(0));
        chk("rst_m_tlast", 64'(o_ml), 64'(0));
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_active_port", 64'(o_ap), 64'(0));
        rst = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mid[p]  = 1'b0;
            hold[p] = 1'b0;
        end
        rdy_pat.delete();
        cur     = -1;
        last_g  = -1;
        idle_at = cyc;
        mfull   = 1'b0;
        ifg     = sel ? 0 : int'(IFG_A);
    endtask

    function automatic bit all_done();
        bit d;
        d = (cur < 0) && !mfull && (cyc >= idle_at);
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) d = 1'b0;
        return d;
    endfunction

    task automatic drain(int limit);
        int n;
        n = 0;
        while (!all_done()) begin
            if (n >= limit) begin
                n_tests++;
                n_fail++;
                $error("FAIL drain_timeout @cycle %0d: traffic still pending after %0d cycles", cyc, limit);
                break;
            end
            cycle();
            n++;
        end
    endtask

    // Reset while port p is presenting beat 2 of a 5-beat frame, then race ports 0 and 3.
    task automatic mid_reset(int p);
        int n;
        reset_dut();
        for (int k = 0; k < 5; k++) push(p, 8'(8'h50 + k), k == 4, 1'b0);
        n = 0;
        while (src_q[p].size() > 4 && n < 20) begin
            cycle();
            n++;
        end
        chk("pre_rst_accepts", 64'(src_q[p].size()), 64'(4));
        reset_dut();
        clear_logs();
        push(0, 8'h60, 1'b1, 1'b0);
        push(3, 8'h63, 1'b1, 1'b0);
        drain(200);
        chk("post_rst_grants", 64'(acc_port.size()), 64'(2));
        if (acc_port.size() == 2) begin
            chk("post_rst_first", 64'(acc_port[0]), 64'(0));
            chk("post_rst_second", 64'(acc_port[1]), 64'(3));
        end
    endtask

    initial begin
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        sel      = 1'b0;
        gaps_en  = 1'b0;
        bp_en    = 1'b0;
        reset_dut();
        reset_dut();

        // Single 3-beat frame from port 2
        clear_logs();
        push(2, 8'hA1, 1'b0, 1'b0);
        push(2, 8'hA2, 1'b0, 1'b0);
        push(2, 8'hA3, 1'b1, 1'b0);
        start = cyc;
        drain(200);
        chk("a_beats", 64'(out_log.size()), 64'(3));
        if (out_log.size() == 3) begin
            chk("a_first_accept", 64'(acc_cyc[0] - start), 64'(1));
            for (int i = 0; i < 3; i++) chk("a_data", 64'(out_log[i].data), 64'(exp_a[i]));
            chk("a_tlast", 64'(out_log[2].last), 64'(1));
            chk("a_back_to_back", 64'(out_cyc[2] - out_cyc[0]), 64'(2));
        end

        // Ports 0,1,3 each with two 1-beat frames
        reset_dut();
        clear_logs();
        for (int k = 0; k < 2; k++) begin
            push(0, 8'(8'h10 + k), 1'b1, 1'b0);
            push(1, 8'(8'h20 + k), 1'b1, 1'b0);
            push(3, 8'(8'h30 + k), 1'b1, 1'b0);
        end
        drain(400);
        chk("rr_grants", 64'(acc_port.size()), 64'(6));
        if (acc_port.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("rr_order", 64'(acc_port[i]), 64'(exp_order[i]));
            for (int i = 1; i < 6; i++) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(IFG_A + 2));
        end

        // Backpressure 1,0,0,1 during a 4-beat frame
        reset_dut();
        clear_logs();
        for (int k = 0; k < 4; k++) push(0, exp_b[k], k == 3, 1'b0);
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b1);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b0);
        rdy_pat.push_back(1'b1);
        drain(200);
        chk("bp_beats", 64'(out_log.size()), 64'(4));
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_data", 64'(out_log[i].data), 64'(exp_b[i]));
            chk("bp_stall_len", 64'(out_cyc[1] - out_cyc[0]), 64'(3));
        end

        // IFG=0 instance: back-to-back 2-beat frames from port 1
        sel = 1'b1;
        reset_dut();
        clear_logs();
        for (int k = 0; k < 4; k++) push(1, 8'(8'h70 + k), k % 2 == 1, 1'b0);
        drain(200);
        chk("ifg0_frames", 64'(acc_cyc.size()), 64'(2));
        if (acc_cyc.size() == 2 && last_cyc.size() == 2) begin
            chk("ifg0_spacing", 64'(acc_cyc[1] - last_cyc[0]), 64'(2));
        end

        // Reset mid-frame (port 3, then port 1 to expose a stale round-robin mask)
        sel = 1'b0;
        mid_reset(3);
        mid_reset(1);

        // Port 0 bubbles mid-frame while port 1 waits; port 1 flags an error on its last beat
        reset_dut();
        clear_logs();
        gaps_en = 1'b1;
        for (int k = 0; k < 6; k++) push(0, 8'(8'h80 + k), k == 5, 1'b0);
        push(1, 8'h90, 1'b0, 1'b0);
        push(1, 8'h91, 1'b1, 1'b1);
        drain(400);
        gaps_en = 1'b0;
        chk("hold_grants", 64'(acc_port.size()), 64'(2));
        chk("hold_beats", 64'(out_log.size()), 64'(8));
        if (acc_port.size() == 2 && out_log.size() == 8) begin
            chk("hold_order", 64'(acc_port[1]), 64'(1));
            chk("hold_spacing", 64'(acc_cyc[1] - last_cyc[0]), 64'(IFG_A + 2));
            chk("hold_tuser_last", 64'(out_log[7].user), 64'(1));
            chk("hold_tuser_first", 64'(out_log[6].user), 64'(0));
        end

        // Randomized traffic on both instances
        for (int ph = 0; ph < 6; ph++) begin
            if (ph % 2 == 0) begin
                sel = (ph == 2);
                reset_dut();
            end
            gaps_en = (ph < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            bp_en   = (ph < 2) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int p = 0; p < NP; p++) begin
                nf = int'($urandom_range(0, 3));
                for (int f = 0; f < nf; f++) begin
                    len = int'($urandom_range(1, 5));
                    for (int b = 0; b < len; b++) push(p, 8'($urandom), b == len - 1, 1'($urandom));
                end
            end
            drain(3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of frame sources (legal range 2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, AXI-stream data width in bits.
REQ-003 SHALL have parameter IFG_CYCLES, default 12, idle cycles enforced after each frame (legal range 0..255).
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: s_axis_tdata  in  PORTS*DATA_WIDTH  source data, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have ports: s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  PORTS  per-source valid, end-of-frame, error flag.
REQ-008 SHALL have ports: s_axis_tready  out  PORTS  per-source ready.
REQ-009 SHALL have ports: m_axis_tdata  out  DATA_WIDTH; m_axis_tvalid, m_axis_tlast, m_axis_tuser  out  1; m_axis_tready  in  1.
REQ-010 SHALL have ports: busy  out  1  high in any state other than IDLE; active_port  out  $clog2(PORTS)  index of granted source.

Function
REQ-011 SHALL implement three states: IDLE, XFER, GAP.
REQ-012 IDLE: when any s_axis_tvalid is high, SHALL grant one port by round robin, latch index into active_port, go to XFER next cycle; otherwise stay IDLE.
REQ-013 Round robin: SHALL keep mask_reg of ports with index greater than the last granted index; lowest-index requesting port within mask wins; if none, lowest-index requesting port overall wins.
REQ-014 SHALL update mask_reg only on a grant, to all indices strictly above the granted index (empty when index = PORTS-1).
REQ-015 Grant SHALL be frame-atomic: active_port is held from grant until the tlast beat of that port is accepted; other ports' tready stay 0 throughout.
REQ-016 XFER: s_axis_tready[active_port] SHALL equal (!m_axis_tvalid || m_axis_tready); all other s_axis_tready bits 0; in IDLE and GAP all s_axis_tready bits 0.
REQ-017 Output register: a source beat accepted in cycle N SHALL appear on m_axis_* in cycle N+1 and hold stable until m_axis_tready is high; m_axis_tvalid clears after acceptance with no new beat loaded.
REQ-018 Throughput: with source valid and m_axis_tready continuously high, SHALL transfer one beat per cycle with no bubbles within a frame.
REQ-019 tdata, tlast, tuser SHALL pass unmodified from the granted port into the output register.
REQ-020 When the tlast beat is accepted from the source in cycle T: if IFG_CYCLES>0 go to GAP for exactly IFG_CYCLES cycles (T+1..T+IFG_CYCLES), then IDLE at T+IFG_CYCLES+1; if IFG_CYCLES=0 go to IDLE at T+1.
REQ-021 GAP counter SHALL be 8 bits, load IFG_CYCLES, decrement each cycle, exit to IDLE on the cycle it reads 1; GAP does not wait for the output register to drain.
REQ-022 Earliest next-frame source acceptance after tlast at T: cycle T+IFG_CYCLES+2.
REQ-023 Source dropping tvalid mid-frame SHALL NOT release the grant; block stalls in XFER until the frame completes.
REQ-024 A one-beat frame (tvalid and tlast together) SHALL be handled as a complete frame, including the gap.
REQ-025 Requests arriving during XFER or GAP SHALL be evaluated only in IDLE; no request is latched or lost (sources hold tvalid per AXI-stream).

Reset
REQ-026 While rst is high at a rising edge: state <= IDLE, gap counter <= 0, mask_reg <= 0, active_port <= 0, m_axis_tvalid/tlast/tuser <= 0, m_axis_tdata <= 0.
REQ-027 During and after reset, s_axis_tready SHALL be 0 and busy 0 until a grant occurs.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, discard the output register contents, and set mask_reg <= 0 so port 0 wins first after reset.

Verification
REQ-029 PORTS=4, IFG=12: port 2 sends 3-beat frame A1,A2,A3, m_axis_tready=1 -> grant at IDLE, A1..A3 on m_axis in consecutive cycles, tlast on A3, busy high until 13 cycles after A3 accepted.
REQ-030 Ports 0,1,3 all requesting continuously, 1-beat frames -> grant order 0,1,3,0,1,3; consecutive source acceptances spaced exactly IFG_CYCLES+2 cycles.
REQ-031 m_axis_tready toggled 1,0,0,1 during a 4-beat frame -> output data held stable while tready=0, no beat dropped or duplicated, source tready low in stall cycles with full register.
REQ-032 IFG_CYCLES=0, port 1 streams back-to-back 2-beat frames -> next frame's first beat accepted exactly 2 cycles after previous tlast accepted.
REQ-033 rst pulsed on 2nd beat of a 5-beat frame from port 3 -> next cycle m_axis_tvalid=0, all s_axis_tready=0; with ports 0 and 3 requesting afterward, port 0 is granted first.
REQ-034 Port 0 tvalid gaps mid-frame while port 1 requests -> port 1 never granted until port 0 tlast accepted and gap elapses; port 1 tuser=1 on last beat reproduced on m_axis_tuser.
